hack_fb_display: RTL and testbench

Parametrised single-clock framebuffer display controller for the Hack platform. It generates raster timing, fetches packed pixels from an internal dual-port VRAM, and expands them to 24-bit RGB through a fixed grayscale ramp or an optional palette. The CPU side is the Hack memory-mapped screen port: word writes and registered reads. The block supports 1, 2 or 4 bits per pixel and any active area whose line is a whole number of 16-bit words.

---
 rtl/hack_fb_display.sv | 185 ++++++++++++++++++
 tb/tb_hack_fb_display.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hack_fb_display.sv
// Hack framebuffer display: raster timing, packed-pixel VRAM fetch and RGB expansion.
// Optional palette is compiled in with `define HACK_FB_PALETTE_EN; otherwise a fixed gray ramp is used.
module hack_fb_display #(
  parameter int BPP      = 1,
  parameter int H_ACTIVE = 512,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 64,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 256,
  parameter int V_FP     = 2,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 2,
  localparam int WPL     = H_ACTIVE * BPP / 16,
  localparam int DEPTH   = WPL * V_ACTIVE,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   in,
  input  logic          load,
  input  logic [AW-1:0] address,
  output logic [15:0]   out,
  input  logic          pal_we,
  input  logic [3:0]    pal_addr,
  input  logic [23:0]   pal_data,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic          hsync,
  output logic          vsync,
  output logic          display_on,
  output logic          frame_irq
);

  localparam int PPW       = 16 / BPP;
  localparam int PPW_LOG   = $clog2(PPW);
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int NCOL      = 1 << BPP;
  localparam int GRAY_STEP = 255 / (NCOL - 1);

  localparam logic [HW:0] H_ACT_W  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG   = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0] V_ACT_W  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG   = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);

  logic [HW-1:0] hpos, hpos_nxt;
  logic [VW-1:0] vpos, vpos_nxt;
  logic [AW-1:0] line_base;
  logic [AW-1:0] vid_addr;
  logic          line_end, frame_end;
  logic          h_act, v_act, h_sync, v_sync;

  logic [15:0]   vram [DEPTH];
  logic          cpu_hit;

  logic [15:0]   vram_q;
  logic          s1_load, s1_act, s1_hs, s1_vs;
  logic [15:0]   shift_q, shift_nxt;
  logic [BPP-1:0] pix_idx;
  logic [23:0]   rgb_lut;

  // raster counters
  assign line_end  = hpos == HW'(H_TOTAL - 1);
  assign frame_end = vpos == VW'(V_TOTAL - 1);

  always_comb begin
    hpos_nxt = line_end ? '0 : hpos + HW'(1);
    vpos_nxt = vpos;
    if (line_end)
      vpos_nxt = frame_end ? '0 : vpos + VW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hpos      <= '0;
      vpos      <= '0;
      line_base <= '0;
      frame_irq <= 1'b0;
    end else begin
      hpos      <= hpos_nxt;
      vpos      <= vpos_nxt;
      // line base stops at the last visible line so it never leaves the VRAM range
      if (line_end) begin
        if (frame_end)
          line_base <= '0;
        else if ({1'b0, vpos} < V_ACT_W - (VW+1)'(1))
          line_base <= line_base + AW'(WPL);
      end
      frame_irq <= (hpos_nxt == '0) && ({1'b0, vpos_nxt} == V_ACT_W);
    end
  end

  assign h_act    = {1'b0, hpos} < H_ACT_W;
  assign v_act    = {1'b0, vpos} < V_ACT_W;
  assign h_sync   = ({1'b0, hpos} >= HS_BEG) && ({1'b0, hpos} < HS_END);
  assign v_sync   = ({1'b0, vpos} >= VS_BEG) && ({1'b0, vpos} < VS_END);
  assign vid_addr = line_base + AW'(hpos >> PPW_LOG);

  // CPU port: writes beyond DEPTH are dropped, reads beyond DEPTH return 0
  assign cpu_hit = {1'b0, address} < DEPTH_W;

  always_ff @(posedge clk) begin
    if (load && cpu_hit)
      vram[address] <= in;
  end

  always_ff @(posedge clk) begin
    if (!reset)
      out <= '0;
    else if (!load)
      out <= cpu_hit ? vram[address] : '0;
  end

  // stage 1: registered VRAM word plus matching control
  always_ff @(posedge clk) begin
    if (!reset) begin
      vram_q  <= '0;
      s1_load <= 1'b0;
      s1_act  <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
    end else begin
      if (h_act && v_act)
        vram_q <= vram[vid_addr];
      s1_load <= hpos[PPW_LOG-1:0] == '0;
      s1_act  <= h_act && v_act;
      s1_hs   <= ~h_sync;
      s1_vs   <= ~v_sync;
    end
  end

  // shifter keeps the current pixel in its top BPP bits
  always_comb begin
    shift_nxt = s1_load ? vram_q : (shift_q << BPP);
    pix_idx   = shift_nxt[15 -: BPP];
  end

`ifdef HACK_FB_PALETTE_EN
  logic [23:0] pal [16];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++)
        pal[i] <= (i < NCOL) ? {3{8'(i * GRAY_STEP)}} : 24'hFF_FFFF;
    end else if (pal_we) begin
      pal[pal_addr] <= pal_data;
    end
  end

  assign rgb_lut = pal[4'(pix_idx)];
`else
  logic [7:0] gray;
  logic       unused_pal;

  assign unused_pal = ^{pal_we, pal_addr, pal_data};
  assign gray       = 8'(pix_idx) * 8'(GRAY_STEP);
  assign rgb_lut    = {gray, gray, gray};
`endif

  // stage 2: pixel select, colour and aligned sync/enable
  always_ff @(posedge clk) begin
    if (!reset) begin
      shift_q    <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      display_on <= 1'b0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
    end else begin
      shift_q    <= shift_nxt;
      {r, g, b}  <= s1_act ? rgb_lut : 24'h0;
      display_on <= s1_act;
      hsync      <= s1_hs;
      vsync      <= s1_vs;
    end
  end

endmodule

// File: tb/tb_hack_fb_display.sv
// Directed bench for hack_fb_display: a small 1 bpp instance (8-word VRAM)
// and a 2 bpp instance with a non power-of-two VRAM (6 words).
module tb_hack_fb_display;

  localparam int FRAME1 = 48 * 7;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in1, out1, in2, out2;
  logic        load1, load2;
  logic [2:0]  a1, a2;
  logic        pal_we1, pal_we2;
  logic [3:0]  pal_addr1, pal_addr2;
  logic [23:0] pal_data1, pal_data2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;
  logic        hs1, vs1, de1, irq1, hs2, vs2, de2, irq2;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  always #5 clk = ~clk;

  hack_fb_display #(
    .BPP(1), .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut1 (
    .clk(clk), .reset(reset), .in(in1), .load(load1), .address(a1), .out(out1),
    .pal_we(pal_we1), .pal_addr(pal_addr1), .pal_data(pal_data1),
    .r(r1), .g(g1), .b(b1), .hsync(hs1), .vsync(vs1), .display_on(de1), .frame_irq(irq1)
  );

  hack_fb_display #(
    .BPP(2), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .clk(clk), .reset(reset), .in(in2), .load(load2), .address(a2), .out(out2),
    .pal_we(pal_we2), .pal_addr(pal_addr2), .pal_data(pal_data2),
    .r(r2), .g(g2), .b(b2), .hsync(hs2), .vsync(vs2), .display_on(de2), .frame_irq(irq2)
  );

  // one clock; edges counts posedges since reset was released
  task automatic tick();
    @(posedge clk);
    if (reset) edges++;
    else edges = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic goto_edge(input int n);
    while (edges < n) tick();
  endtask

  task automatic write1(input logic [2:0] addr, input logic [15:0] data);
    a1 = addr; in1 = data; load1 = 1'b1;
    tick();
    load1 = 1'b0;
  endtask

  task automatic write2(input logic [2:0] addr, input logic [15:0] data);
    a2 = addr; in2 = data; load2 = 1'b1;
    tick();
    load2 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    write1(3'd3, 16'h00FF);
    a1 = 3'd3;
    tick();
    goto_edge(40);
    reset = 1'b0;
    repeat (3) tick();
    n_cmp++; if (out1 !== 16'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0000", out1); end
    n_cmp++; if ({r1, g1, b1} !== 24'h0) begin n_bad++; $display("FAIL reset_rgb: got %h want 000000", {r1, g1, b1}); end
    n_cmp++; if (hs1 !== 1'b1) begin n_bad++; $display("FAIL reset_hsync: got %b want 1", hs1); end
    n_cmp++; if (vs1 !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b want 1", vs1); end
    n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL reset_display_on: got %b want 0", de1); end
    n_cmp++; if (irq1 !== 1'b0) begin n_bad++; $display("FAIL reset_frame_irq: got %b want 0", irq1); end
    n_cmp++; if (out2 !== 16'h0 || hs2 !== 1'b1 || de2 !== 1'b0) begin
      n_bad++; $display("FAIL reset_dut2: got out=%h hs=%b de=%b want 0000/1/0", out2, hs2, de2);
    end
    reset = 1'b1;
    tick();
    n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL release_de_e1: got %b want 0", de1); end
    tick();
    n_cmp++; if (de1 !== 1'b1) begin n_bad++; $display("FAIL release_de_e2: got %b want 1", de1); end
  endtask

  task automatic test_bpp1();
    logic [23:0] exp;
    write1(3'd0, 16'h8001);
    do_reset();
    for (int h = 0; h < 16; h++) begin
      goto_edge(h + 2);
      exp = (h == 0 || h == 15) ? 24'hFFFFFF : 24'h000000;
      n_cmp++;
      if ({r1, g1, b1} !== exp) begin
        n_bad++; $display("FAIL bpp1_pixel%0d: got %h want %h", h, {r1, g1, b1}, exp);
      end
    end
  endtask

  task automatic test_readback();
    a1 = 3'd0; load1 = 1'b0;
    tick();
    n_cmp++; if (out1 !== 16'h8001) begin n_bad++; $display("FAIL read_addr0: got %h want 8001", out1); end
    a1 = 3'd5; in1 = 16'h1234; load1 = 1'b1;
    tick();
    n_cmp++; if (out1 !== 16'h8001) begin n_bad++; $display("FAIL out_hold_on_load: got %h want 8001", out1); end
    load1 = 1'b0;
    tick();
    n_cmp++; if (out1 !== 16'h1234) begin n_bad++; $display("FAIL read_addr5: got %h want 1234", out1); end
    write2(3'd2, 16'h5A5A);
    write2(3'd6, 16'hDEAD);
    a2 = 3'd2;
    tick();
    n_cmp++; if (out2 !== 16'h5A5A) begin n_bad++; $display("FAIL read2_addr2: got %h want 5a5a", out2); end
    a2 = 3'd6;
    tick();
    n_cmp++; if (out2 !== 16'h0) begin n_bad++; $display("FAIL read2_depth: got %h want 0000", out2); end
    a2 = 3'd7;
    tick();
    n_cmp++; if (out2 !== 16'h0) begin n_bad++; $display("FAIL read2_above_depth: got %h want 0000", out2); end
  endtask

  task automatic test_bpp2();
    logic [23:0] exp;
    write2(3'd0, 16'h1B00);
    do_reset();
    for (int h = 0; h < 8; h++) begin
      goto_edge(h + 2);
      case (h)
        1:       exp = 24'h555555;
        2:       exp = 24'hAAAAAA;
        3:       exp = 24'hFFFFFF;
        default: exp = 24'h000000;
      endcase
      n_cmp++;
      if ({r2, g2, b2} !== exp) begin
        n_bad++; $display("FAIL bpp2_pixel%0d: got %h want %h", h, {r2, g2, b2}, exp);
      end
    end
  endtask

  // address 0 still holds 8001; the rewrite to 8000 collides with the first video fetch
  task automatic test_palette();
    logic [23:0] col1;
`ifdef HACK_FB_PALETTE_EN
    col1 = 24'h00FF00;
`else
    col1 = 24'hFFFFFF;
`endif
    do_reset();
    pal_we1 = 1'b1; pal_addr1 = 4'd1; pal_data1 = 24'h00FF00;
    a1 = 3'd0; in1 = 16'h8000; load1 = 1'b1;
    tick();
    pal_we1 = 1'b0; load1 = 1'b0;
    goto_edge(2);
    n_cmp++; if ({r1, g1, b1} !== col1) begin n_bad++; $display("FAIL pal_f0_px0: got %h want %h", {r1, g1, b1}, col1); end
    goto_edge(3);
    n_cmp++; if ({r1, g1, b1} !== 24'h0) begin n_bad++; $display("FAIL pal_f0_px1: got %h want 000000", {r1, g1, b1}); end
    goto_edge(17);
    n_cmp++; if ({r1, g1, b1} !== col1) begin n_bad++; $display("FAIL collision_old_px15: got %h want %h", {r1, g1, b1}, col1); end
    goto_edge(FRAME1 + 2);
    n_cmp++; if ({r1, g1, b1} !== col1) begin n_bad++; $display("FAIL pal_f1_px0: got %h want %h", {r1, g1, b1}, col1); end
    goto_edge(FRAME1 + 17);
    n_cmp++; if ({r1, g1, b1} !== 24'h0) begin n_bad++; $display("FAIL collision_new_px15: got %h want 000000", {r1, g1, b1}); end
  endtask

  task automatic test_frame_timing();
    int irq_cnt, irq_first, irq_second, hs_low, hs_first, vs_low, irq2_cnt;
    irq_cnt = 0; irq_first = -1; irq_second = -1;
    hs_low = 0; hs_first = -1; vs_low = 0; irq2_cnt = 0;
    do_reset();
    for (int n = 1; n <= 2 * FRAME1 + 4; n++) begin
      tick();
      if (irq1 === 1'b1) begin
        irq_cnt++;
        if (irq_first < 0) irq_first = n;
        else if (irq_second < 0) irq_second = n;
      end
      if (n >= 2 && n < 50 && hs1 === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = n;
      end
      if (n >= 2 && n < FRAME1 + 2 && vs1 === 1'b0) vs_low++;
      if (irq2 === 1'b1) irq2_cnt++;
    end
    n_cmp++; if (irq_cnt != 2) begin n_bad++; $display("FAIL irq_count: got %0d want 2", irq_cnt); end
    n_cmp++; if (irq_first != 192) begin n_bad++; $display("FAIL irq_first_edge: got %0d want 192", irq_first); end
    n_cmp++; if (irq_second - irq_first != FRAME1) begin
      n_bad++; $display("FAIL irq_period: got %0d want %0d", irq_second - irq_first, FRAME1);
    end
    n_cmp++; if (hs_low != 8) begin n_bad++; $display("FAIL hsync_width: got %0d want 8", hs_low); end
    n_cmp++; if (hs_first != 38) begin n_bad++; $display("FAIL hsync_start: got %0d want 38", hs_first); end
    n_cmp++; if (vs_low != 48) begin n_bad++; $display("FAIL vsync_width: got %0d want 48", vs_low); end
    n_cmp++; if (irq2_cnt != 5) begin n_bad++; $display("FAIL irq2_count: got %0d want 5", irq2_cnt); end
  endtask

  task automatic test_mid_reset();
    int hs_first, irq_first;
    hs_first = -1; irq_first = -1;
    do_reset();
    goto_edge(100);
    do_reset();
    tick();
    n_cmp++; if (de1 !== 1'b0) begin n_bad++; $display("FAIL midrst_de_e1: got %b want 0", de1); end
    tick();
    n_cmp++; if (de1 !== 1'b1) begin n_bad++; $display("FAIL midrst_de_e2: got %b want 1", de1); end
    while (edges < 200) begin
      tick();
      if (hs_first < 0 && hs1 === 1'b0) hs_first = edges;
      if (irq_first < 0 && irq1 === 1'b1) irq_first = edges;
    end
    n_cmp++; if (hs_first != 38) begin n_bad++; $display("FAIL midrst_hsync_start: got %0d want 38", hs_first); end
    n_cmp++; if (irq_first != 192) begin n_bad++; $display("FAIL midrst_irq_edge: got %0d want 192", irq_first); end
  endtask

  initial begin
    reset = 1'b0;
    in1 = '0; load1 = 1'b0; a1 = '0; pal_we1 = 1'b0; pal_addr1 = '0; pal_data1 = '0;
    in2 = '0; load2 = 1'b0; a2 = '0; pal_we2 = 1'b0; pal_addr2 = '0; pal_data2 = '0;
    @(negedge clk);
    test_reset();
    test_bpp1();
    test_readback();
    test_bpp2();
    test_palette();
    test_frame_timing();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
